memctrl_mp: RTL and testbench

MEMCTRL_MP -- requirements
Module: memctrl_mp

---
 rtl/memctrl_mp.sv | 232 +++++++++++++++++++++++
 tb/tb_memctrl_mp.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memctrl_mp.sv
// memctrl_mp: multi-port memory controller. An instruction-fetch port
// (read-only) and a load/store port share one byte-serial main memory.
//
// Configuration macro: MEMCTRL_IF_FLUSH_EN. When it is defined, if_flush_i
// aborts a fetch in progress. When it is undefined, the port exists but is ignored.
//
// Handshake (both request ports): the requester raises *_req_i with stable
// operands and holds them until it sees the one-cycle *_done_o pulse.
// Requests are sampled only in IDLE. In the cycle a done pulse is visible,
// the completing port's request is masked, so a still-held request is not
// served twice. The other port, or a new request, may be accepted in that
// same cycle.
//
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   if_req_i/if_addr_i     fetch request and byte address
//   if_flush_i             fetch abort (MEMCTRL_IF_FLUSH_EN only)
//   ls_req_i/ls_we_i/ls_size_i/ls_unsigned_i/ls_addr_i/ls_wdata_i
//                          load/store request (size 00 byte, 01 half, 10 word)
//   if_done_o/if_pc_o/if_inst_o   fetch completion pulse, address, word
//   ls_done_o/ls_rdata_o          load/store completion pulse, extended data
//   busy_o                 transfer in progress
//   mmem_din_i             memory read byte (valid one cycle after address)
//   mmem_rw_o/mmem_addr_o/mmem_dout_o   memory strobe, address, write byte
//   state_o                current FSM state (debug)
module memctrl_mp #(
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    if_req_i,
  input  logic [ADDR_W-1:0]       if_addr_i,
  input  logic                    if_flush_i,
  input  logic                    ls_req_i,
  input  logic                    ls_we_i,
  input  logic [1:0]              ls_size_i,
  input  logic                    ls_unsigned_i,
  input  logic [ADDR_W-1:0]       ls_addr_i,
  input  logic [8*WORD_BYTES-1:0] ls_wdata_i,
  output logic                    if_done_o,
  output logic [ADDR_W-1:0]       if_pc_o,
  output logic [8*WORD_BYTES-1:0] if_inst_o,
  output logic                    ls_done_o,
  output logic [8*WORD_BYTES-1:0] ls_rdata_o,
  output logic                    busy_o,
  input  logic [7:0]              mmem_din_i,
  output logic                    mmem_rw_o,
  output logic [ADDR_W-1:0]       mmem_addr_o,
  output logic [7:0]              mmem_dout_o,
  output logic [1:0]              state_o
);

  localparam int DW = 8 * WORD_BYTES;
  localparam logic [2:0] WB = 3'(WORD_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_IF_RD, S_LS_RD, S_LS_WR} state_e;

  state_e              state_q;
  logic [2:0]          cyc_q;      // cycle index since accept (1 = first byte)
  logic [2:0]          len_q;      // byte count of current transfer
  logic [ADDR_W-1:0]   base_q;
  logic [DW-1:0]       wdata_q;
  logic                sext_q;
  logic [DW-1:0]       acc_q;      // read bytes collected so far
  logic                busy_q;
  logic                mem_rw_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [7:0]          mem_dout_q;
  logic                if_done_q;
  logic [ADDR_W-1:0]   if_pc_q;
  logic [DW-1:0]       if_inst_q;
  logic                ls_done_q;
  logic [DW-1:0]       ls_rdata_q;

  logic [2:0]          ls_len;
  logic                ls_go;
  logic                if_go;
  logic                if_abort;
  logic [2:0]          rd_idx;
  logic [DW-1:0]       acc_d;
  logic [DW-1:0]       keep;
  logic                sbit;
  logic [DW-1:0]       ext_d;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [7:0]          wbyte_nxt;

`ifdef MEMCTRL_IF_FLUSH_EN
  assign if_abort = (state_q == S_IF_RD) && if_flush_i;
`else
  logic unused_flush;
  assign if_abort     = 1'b0;
  assign unused_flush = if_flush_i;
`endif

  // A held request is masked in the cycle its own completion is visible.
  assign ls_go = ls_req_i && !ls_done_q;
  assign if_go = if_req_i && !if_done_q;

  always_comb begin
    case (ls_size_i)
      2'b00:   ls_len = 3'd1;
      2'b01:   ls_len = 3'd2;
      default: ls_len = WB;
    endcase
  end

  // Byte i is addressed in cycle i+1 and returns in cycle i+2.
  assign rd_idx    = cyc_q - 3'd2;
  assign acc_d     = (cyc_q >= 3'd2) ? (acc_q | (DW'(mmem_din_i) << {rd_idx, 3'b000}))
                                     : acc_q;
  assign addr_nxt  = base_q + ADDR_W'(cyc_q);
  assign wbyte_nxt = 8'(wdata_q >> {cyc_q, 3'b000});

  always_comb begin
    case (len_q)
      3'd1:    begin keep = DW'(8'hFF);    sbit = acc_d[7];    end
      3'd2:    begin keep = DW'(16'hFFFF); sbit = acc_d[15];   end
      default: begin keep = '1;            sbit = acc_d[DW-1]; end
    endcase
    ext_d = (sext_q && sbit) ? (acc_d | ~keep) : (acc_d & keep);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      cyc_q      <= '0;
      len_q      <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      sext_q     <= 1'b0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      mem_rw_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_dout_q <= '0;
      if_done_q  <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= '0;
      ls_done_q  <= 1'b0;
      ls_rdata_q <= '0;
    end else begin
      if_done_q <= 1'b0;
      ls_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ls_go) begin
            if (ls_size_i == 2'b11) begin
              // Illegal size: complete at once without touching memory.
              ls_done_q  <= 1'b1;
              ls_rdata_q <= '0;
            end else begin
              state_q    <= ls_we_i ? S_LS_WR : S_LS_RD;
              base_q     <= ls_addr_i;
              len_q      <= ls_len;
              sext_q     <= !ls_unsigned_i;
              wdata_q    <= ls_wdata_i;
              cyc_q      <= 3'd1;
              acc_q      <= '0;
              busy_q     <= 1'b1;
              mem_addr_q <= ls_addr_i;
              mem_rw_q   <= ls_we_i;
              mem_dout_q <= ls_we_i ? ls_wdata_i[7:0] : 8'h00;
            end
          end else if (if_go) begin
            state_q    <= S_IF_RD;
            base_q     <= if_addr_i;
            len_q      <= WB;
            sext_q     <= 1'b0;
            cyc_q      <= 3'd1;
            acc_q      <= '0;
            busy_q     <= 1'b1;
            mem_addr_q <= if_addr_i;
            mem_rw_q   <= 1'b0;
            mem_dout_q <= 8'h00;
          end
        end
        S_IF_RD, S_LS_RD: begin
          if (if_abort) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            mem_addr_q <= '0;
          end else begin
            acc_q      <= acc_d;
            cyc_q      <= cyc_q + 3'd1;
            mem_addr_q <= (cyc_q < len_q) ? addr_nxt : '0;
            if (cyc_q == len_q + 3'd1) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              if (state_q == S_IF_RD) begin
                if_done_q <= 1'b1;
                if_pc_q   <= base_q;
                if_inst_q <= acc_d;
              end else begin
                ls_done_q  <= 1'b1;
                ls_rdata_q <= ext_d;
              end
            end
          end
        end
        S_LS_WR: begin
          cyc_q <= cyc_q + 3'd1;
          if (cyc_q < len_q) begin
            mem_addr_q <= addr_nxt;
            mem_dout_q <= wbyte_nxt;
          end else begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            mem_rw_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_dout_q <= 8'h00;
            ls_done_q  <= 1'b1;
            ls_rdata_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign if_done_o   = if_done_q;
  assign if_pc_o     = if_pc_q;
  assign if_inst_o   = if_inst_q;
  assign ls_done_o   = ls_done_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign busy_o      = busy_q;
  assign mmem_rw_o   = mem_rw_q;
  assign mmem_addr_o = mem_addr_q;
  assign mmem_dout_o = mem_dout_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_memctrl_mp.sv
module tb_memctrl_mp;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_size;
  logic        ls_unsigned;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        if_done;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        busy;
  logic [7:0]  mmem_din;
  logic        mmem_rw;
  logic [31:0] mmem_addr;
  logic [7:0]  mmem_dout;
  logic [1:0]  state;

  memctrl_mp #(.ADDR_W(32), .WORD_BYTES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_size_i(ls_size),
    .ls_unsigned_i(ls_unsigned), .ls_addr_i(ls_addr), .ls_wdata_i(ls_wdata),
    .if_done_o(if_done), .if_pc_o(if_pc), .if_inst_o(if_inst),
    .ls_done_o(ls_done), .ls_rdata_o(ls_rdata), .busy_o(busy),
    .mmem_din_i(mmem_din), .mmem_rw_o(mmem_rw), .mmem_addr_o(mmem_addr),
    .mmem_dout_o(mmem_dout), .state_o(state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model (256-byte window, read latency 1) ----------------
  logic [7:0] mem [0:255];
  always @(posedge clk) mmem_din <= mem[mmem_addr[7:0]];

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_pass = 0;
  logic [40:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] t;
      t = w >> (8 * i);
      mem[8'(a[7:0] + 8'(i))] = t[7:0];
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mword;
    logic [31:0] exp_rdata;
    int          exp_done;
    int          nbytes;
  } vec_t;

  vec_t vecs[14];

  // ---------------- driver tasks (called at a negedge = cycle 0) ----------------
  task automatic run_ls(input vec_t v);
    int done_cyc;
    logic [31:0] rd;
    done_cyc = 0;
    rd = 32'h0;
    exp_q.delete();
    if (!v.we) set_word(v.addr, v.mword);
    for (int i = 0; i < v.nbytes; i++) begin
      logic [31:0] t;
      t = v.wdata >> (8 * i);
      exp_q.push_back({v.we, v.we ? t[7:0] : 8'h00, v.addr + 32'(i)});
    end
    ls_req = 1'b1; ls_we = v.we; ls_size = v.size; ls_unsigned = v.uns;
    ls_addr = v.addr; ls_wdata = v.wdata;
    for (int cyc = 1; cyc <= 12 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      if (cyc <= v.nbytes && exp_q.size() > 0)
        check("ls_bus", {mmem_rw, mmem_dout, mmem_addr}, exp_q.pop_front());
      if (v.nbytes == 0 && cyc == 1)
        check("ls_noaccess", {mmem_rw, mmem_addr}, 64'h0);
      check("ls_busy", busy, (cyc < v.exp_done && v.nbytes != 0) ? 1 : 0);
      if (ls_done) begin
        done_cyc = cyc;
        rd = ls_rdata;
        ls_req = 1'b0;
      end
    end
    ls_req = 1'b0;
    check("ls_done_cycle", done_cyc, v.exp_done);
    check("ls_rdata", rd, v.exp_rdata);
    @(negedge clk);
    check("ls_done_pulse", ls_done, 0);
    check("ls_rdata_hold", ls_rdata, v.exp_rdata);
  endtask

  task automatic run_if(input logic [31:0] a, input logic [31:0] w);
    int done_cyc;
    logic [31:0] inst;
    logic [31:0] pc;
    done_cyc = 0;
    inst = 32'h0;
    pc = 32'h0;
    set_word(a, w);
    if_req = 1'b1; if_addr = a;
    for (int cyc = 1; cyc <= 12 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      if (cyc <= 4) check("if_addr", {mmem_rw, mmem_addr}, {1'b0, a + 32'(cyc - 1)});
      if (if_done) begin
        done_cyc = cyc; inst = if_inst; pc = if_pc; if_req = 1'b0;
      end
    end
    if_req = 1'b0;
    check("if_done_cycle", done_cyc, 6);
    check("if_inst", inst, w);
    check("if_pc", pc, a);
    @(negedge clk);
    check("if_done_pulse", if_done, 0);
    check("if_inst_hold", if_inst, w);
  endtask

  // ---------------- test ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b00; ls_unsigned = 1'b0;
    ls_addr = '0; ls_wdata = '0;

    //            we   size   uns  addr          wdata         mword         exp_rdata     done n
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h00000020, 32'h0,        32'h00000080, 32'hFFFFFF80, 3, 1};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h00000020, 32'h0,        32'h00000080, 32'h00000080, 3, 1};
    vecs[2]  = '{1'b0, 2'b01, 1'b0, 32'h00000030, 32'h0,        32'h0000F234, 32'hFFFFF234, 4, 2};
    vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h00000030, 32'h0,        32'h0000F234, 32'h0000F234, 4, 2};
    vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h00000032, 32'h0,        32'h00001234, 32'h00001234, 4, 2};
    vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'h00000050, 32'h0,        32'h12345678, 32'h12345678, 6, 4};
    vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h00000054, 32'h0,        32'h87654321, 32'h87654321, 6, 4};
    vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h00000040, 32'hDEADBEEF, 32'h0,        32'h00000000, 5, 4};
    vecs[8]  = '{1'b1, 2'b00, 1'b0, 32'h00000061, 32'h1122335A, 32'h0,        32'h00000000, 2, 1};
    vecs[9]  = '{1'b1, 2'b01, 1'b0, 32'h00000062, 32'h0000BEEF, 32'h0,        32'h00000000, 3, 2};
    vecs[10] = '{1'b0, 2'b11, 1'b0, 32'h00000070, 32'h0,        32'h55555555, 32'h00000000, 1, 0};
    vecs[11] = '{1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0,        32'hA1B2C3D4, 32'hA1B2C3D4, 6, 4};
    vecs[12] = '{1'b0, 2'b00, 1'b0, 32'h00000023, 32'h0,        32'h0000007F, 32'h0000007F, 3, 1};
    vecs[13] = '{1'b1, 2'b11, 1'b0, 32'h00000070, 32'hFFFFFFFF, 32'h0,        32'h00000000, 1, 0};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_done", {if_done, ls_done, busy, mmem_rw}, 64'h0);
    check("rst_mem", {mmem_addr, mmem_dout}, 64'h0);
    check("rst_state", state, 0);
    rst_n = 1'b1;

    // instruction fetch at 0x1000
    run_if(32'h00001000, 32'h93000013);

    // load/store table
    for (int k = 0; k < 14; k++) run_ls(vecs[k]);

    // simultaneous requests: LS wins, IF accepted on the ls_done cycle
    begin
      int ls_dc, if_dc;
      logic [31:0] lsd, inst, pc;
      ls_dc = 0; if_dc = 0; lsd = 0; inst = 0; pc = 0;
      set_word(32'h80, 32'hCAFEF00D);
      set_word(32'h1010, 32'h01234567);
      ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_unsigned = 1'b0; ls_addr = 32'h80;
      if_req = 1'b1; if_addr = 32'h1010;
      for (int cyc = 1; cyc <= 20 && if_dc == 0; cyc++) begin
        @(negedge clk);
        if (cyc == 1) check("arb_ls_first", mmem_addr, 32'h80);
        if (cyc == 7) check("arb_if_nobubble", mmem_addr, 32'h1010);
        if (ls_done) begin ls_dc = cyc; lsd = ls_rdata; ls_req = 1'b0; end
        if (if_done) begin if_dc = cyc; inst = if_inst; pc = if_pc; if_req = 1'b0; end
      end
      ls_req = 1'b0; if_req = 1'b0;
      check("arb_ls_done_cycle", ls_dc, 6);
      check("arb_ls_rdata", lsd, 32'hCAFEF00D);
      check("arb_if_done_cycle", if_dc, 12);
      check("arb_if_inst", inst, 32'h01234567);
      check("arb_if_pc", pc, 32'h1010);
      @(negedge clk);
    end

    // if_flush during cycle 2 of a fetch
    begin
      int dc;
      dc = 0;
      set_word(32'h2000, 32'h0BADF00D);
      if_req = 1'b1; if_addr = 32'h2000;
      @(negedge clk);
      @(negedge clk);
      if_flush = 1'b1; if_req = 1'b0;
      @(negedge clk);
      if_flush = 1'b0;
`ifdef MEMCTRL_IF_FLUSH_EN
      check("flush_busy", busy, 0);
      check("flush_addr", mmem_addr, 32'h0);
      for (int cyc = 4; cyc <= 9; cyc++) begin
        @(negedge clk);
        if (if_done) dc = cyc;
      end
      check("flush_no_done", dc, 0);
`else
      check("noflush_busy", busy, 1);
      for (int cyc = 4; cyc <= 12 && dc == 0; cyc++) begin
        @(negedge clk);
        if (if_done) dc = cyc;
      end
      check("noflush_done_cycle", dc, 6);
      check("noflush_inst", if_inst, 32'h0BADF00D);
`endif
      @(negedge clk);
    end

    // reset in cycle 3 of a fetch, then fetch on the first edge after release
    begin
      set_word(32'h1000, 32'h93000013);
      if_req = 1'b1; if_addr = 32'h1000;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0; if_req = 1'b0;
      @(negedge clk);
      check("midrst_ctrl", {if_done, ls_done, busy, mmem_rw, mmem_dout}, 64'h0);
      check("midrst_addr_pc", {mmem_addr, if_pc}, 64'h0);
      check("midrst_data", {if_inst, ls_rdata}, 64'h0);
      check("midrst_state", state, 0);
      rst_n = 1'b1;
      run_if(32'h00001004, 32'h00A00513);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
